// File: rtl/csr_access_ctrl.sv
// Sequences CSR RW/RS/RC instructions into separate read and write cycles on the CSR unit.
// Define CSR_DEBUG_PORT_EN to add a round-robin arbitrated debug requester.
module csr_access_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_func,
    input  logic [XLEN-1:0]   req_src,
    input  logic              req_src_zero,
    input  logic              req_rd_zero,
    input  logic [1:0]        priv_mode,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_illegal,
    output logic [ADDR_W-1:0] csr_addr,
    output logic              csr_read,
    output logic              csr_write,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic              csr_illegal,
`ifdef CSR_DEBUG_PORT_EN
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic              dbg_req_write,
    input  logic [XLEN-1:0]   dbg_req_wdata,
    output logic              dbg_resp_valid,
    output logic [XLEN-1:0]   dbg_resp_data,
    output logic              dbg_resp_err,
    input  logic              dbg_resp_ready,
`endif
    output logic [1:0]        fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a valid response holds its payload stable until taken, and ready never waits on valid.

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] FUNC_RW = 2'b01;
    localparam logic [1:0] FUNC_RS = 2'b10;
    localparam logic [1:0] FUNC_RC = 2'b11;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        func_q;
    logic [XLEN-1:0]   src_q, old_q, data_q, wdata_calc;
    logic              do_write_q, illegal_q;

    logic              sel_valid, sel_rd, sel_wr, pre_fail, idle, resp_hs;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_func, sel_priv;
    logic [XLEN-1:0]   sel_src;

    assign idle      = reset && (state_q == IDLE);
    assign fsm_state = state_q;

`ifdef CSR_DEBUG_PORT_EN
    logic dbg_q, last_dbg_q, sel_dbg;

    // The side not granted last time wins a tie.
    assign req_ready      = idle && (!dbg_req_valid || last_dbg_q);
    assign dbg_req_ready  = idle && (!req_valid || !last_dbg_q);
    assign resp_valid     = (state_q == RESP) && !dbg_q;
    assign dbg_resp_valid = (state_q == RESP) && dbg_q;
    assign dbg_resp_data  = data_q;
    assign dbg_resp_err   = illegal_q;
    assign resp_hs        = (resp_valid && resp_ready) || (dbg_resp_valid && dbg_resp_ready);
`else
    assign req_ready  = idle;
    assign resp_valid = (state_q == RESP);
    assign resp_hs    = resp_valid && resp_ready;
`endif

    assign resp_data    = data_q;
    assign resp_illegal = illegal_q;
    assign csr_read     = (state_q == READ);
    assign csr_write    = (state_q == WRITE);
    assign csr_addr     = (csr_read || csr_write) ? addr_q : '0;
    assign csr_wdata    = csr_write ? wdata_calc : '0;

    always_comb begin
        sel_valid = req_valid && req_ready;
        sel_addr  = req_addr;
        sel_func  = req_func;
        sel_src   = req_src;
        sel_rd    = (req_func != FUNC_RW) || !req_rd_zero;
        sel_wr    = (req_func == FUNC_RW) || !req_src_zero;
        sel_priv  = priv_mode;
`ifdef CSR_DEBUG_PORT_EN
        sel_dbg   = 1'b0;
        // Debug accesses run as M-mode RW and always return the old value.
        if (dbg_req_valid && dbg_req_ready) begin
            sel_valid = 1'b1;
            sel_addr  = dbg_req_addr;
            sel_func  = FUNC_RW;
            sel_src   = dbg_req_wdata;
            sel_rd    = 1'b1;
            sel_wr    = dbg_req_write;
            sel_priv  = 2'b11;
            sel_dbg   = 1'b1;
        end
`endif
        pre_fail = (sel_func == 2'b00)
                || (sel_addr[ADDR_W-3 -: 2] > sel_priv)
                || ((sel_addr[ADDR_W-1 -: 2] == 2'b11) && sel_wr);
    end

    always_comb begin
        wdata_calc = src_q;
        case (func_q)
            FUNC_RS: wdata_calc = old_q | src_q;
            FUNC_RC: wdata_calc = old_q & ~src_q;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (sel_valid) begin
                if (pre_fail)    state_d = RESP;
                else if (sel_rd) state_d = READ;
                else             state_d = WRITE;
            end
            READ:  state_d = (!csr_illegal && do_write_q) ? WRITE : RESP;
            WRITE: state_d = RESP;
            RESP:  if (resp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            func_q     <= '0;
            src_q      <= '0;
            old_q      <= '0;
            data_q     <= '0;
            do_write_q <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef CSR_DEBUG_PORT_EN
            dbg_q      <= 1'b0;
            last_dbg_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: if (sel_valid) begin
                    addr_q     <= sel_addr;
                    func_q     <= sel_func;
                    src_q      <= sel_src;
                    old_q      <= '0;
                    data_q     <= '0;
                    do_write_q <= sel_wr;
                    illegal_q  <= pre_fail;
`ifdef CSR_DEBUG_PORT_EN
                    dbg_q      <= sel_dbg;
                    last_dbg_q <= sel_dbg;
`endif
                end
                READ: begin
                    old_q <= csr_rdata;
                    if (csr_illegal) begin
                        illegal_q <= 1'b1;
                        data_q    <= '0;
                    end else begin
                        data_q    <= csr_rdata;
                    end
                end
                WRITE: if (csr_illegal) begin
                    illegal_q <= 1'b1;
                    data_q    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
